// File: rtl/mem_error_recovery_ctrl.sv
// Recovery sequencer for faulty LABFT array memories: captures the detector's error vector,
// re-arms the detector, then requests recompute/reload of each flagged memory in index order.
module mem_error_recovery_ctrl #(
    parameter int unsigned arraySize  = 4,
    parameter int unsigned maxRetries = 3,
    parameter int unsigned ackTimeout = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [6*arraySize-1:0]          error,
    output logic                            interrupt,
    output logic                            recover_req,
    output logic [$clog2(6*arraySize)-1:0]  recover_idx,
    input  logic                            recover_ack,
    input  logic                            recover_fail,
    output logic                            busy,
    output logic                            fatal,
    output logic [15:0]                     err_count
);

    localparam int unsigned ErrW   = 6 * arraySize;
    localparam int unsigned IdxW   = $clog2(ErrW);
    localparam int unsigned RetryW = (maxRetries > 0) ? $clog2(maxRetries + 1) : 1;
    localparam int unsigned TimerW = (ackTimeout > 1) ? $clog2(ackTimeout + 1) : 1;

    localparam logic [RetryW-1:0] RetryMax  = RetryW'(maxRetries);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(ackTimeout - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StSelect,
        StRequest,
        StRetry,
        StDone,
        StFatal
    } state_e;

    state_e              state_q, state_d;
    logic [ErrW-1:0]     pending_q, pending_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [15:0]         cnt_q, cnt_d;

    // Scanning downward lets the lowest set bit overwrite any higher one.
    function automatic logic [IdxW-1:0] lowest_set(input logic [ErrW-1:0] vec);
        logic [IdxW-1:0] r;
        r = '0;
        for (int i = int'(ErrW) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r = IdxW'(i);
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (error != '0) begin
                    pending_d = error;
                    state_d   = StCapture;
                end
            end

            StCapture: begin
                state_d = StSelect;
            end

            StSelect: begin
                if (pending_q == '0) begin
                    state_d = StDone;
                end else begin
                    idx_d   = lowest_set(pending_q);
                    retry_d = '0;
                    timer_d = '0;
                    state_d = StRequest;
                end
            end

            StRequest: begin
                timer_d = timer_q + 1'b1;
                if (recover_ack) begin
                    if (!recover_fail) begin
                        pending_d[idx_q] = 1'b0;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        state_d = StSelect;
                    end else if (retry_q < RetryMax) begin
                        retry_d = retry_q + 1'b1;
                        timer_d = '0;
                        state_d = StRetry;
                    end else begin
                        state_d = StFatal;
                    end
                end else if (timer_q == TimerLast) begin
                    state_d = StFatal;
                end
            end

            // One idle cycle so each retry shows up as a fresh rising edge on recover_req.
            StRetry: begin
                state_d = StRequest;
            end

            StDone: begin
                state_d = StIdle;
            end

            StFatal: begin
                state_d = StFatal;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign interrupt   = (state_q == StCapture);
    assign recover_req = (state_q == StRequest);
    assign recover_idx = idx_q;
    assign busy        = (state_q != StIdle) && (state_q != StFatal);
    assign fatal       = (state_q == StFatal);
    assign err_count   = cnt_q;

endmodule

// File: tb/tb_mem_error_recovery_ctrl.sv
// Self-checking bench for mem_error_recovery_ctrl: directed and randomized recovery scenarios
// checked against a transaction-level model of the request/ack protocol.
module tb_mem_error_recovery_ctrl;

    localparam int unsigned ArraySize  = 4;
    localparam int unsigned MaxRetries = 3;
    localparam int unsigned AckTimeout = 255;
    localparam int unsigned ErrW       = 6 * ArraySize;

    logic              clk;
    logic              rst;
    logic [ErrW-1:0]   error;
    logic              interrupt;
    logic              recover_req;
    logic [4:0]        recover_idx;
    logic              recover_ack;
    logic              recover_fail;
    logic              busy;
    logic              fatal;
    logic [15:0]       err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-memory response plan: number of failing acks before success (>MaxRetries means
    // never succeeds), and ack delay in cycles (negative means never ack).
    int fails_plan [ErrW];
    int delay_plan [ErrW];

    logic [15:0] exp_cnt;
    int intr_cnt = 0;
    int rise_cnt = 0;
    logic req_prev = 1'b0;

    mem_error_recovery_ctrl #(
        .arraySize (ArraySize),
        .maxRetries(MaxRetries),
        .ackTimeout(AckTimeout)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .error       (error),
        .interrupt   (interrupt),
        .recover_req (recover_req),
        .recover_idx (recover_idx),
        .recover_ack (recover_ack),
        .recover_fail(recover_fail),
        .busy        (busy),
        .fatal       (fatal),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        req_prev <= recover_req;
        if (interrupt) intr_cnt <= intr_cnt + 1;
        if (recover_req && !req_prev) rise_cnt <= rise_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        for (int i = 0; i < int'(ErrW); i++) begin
            fails_plan[i] = 0;
            delay_plan[i] = 0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        chk("rst_interrupt", 32'(interrupt), 0);
        chk("rst_req", 32'(recover_req), 0);
        chk("rst_idx", 32'(recover_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fatal", 32'(fatal), 0);
        chk("rst_count", 32'(err_count), 0);
        exp_cnt = '0;
        error = '0;
        recover_ack = 1'b0;
        recover_fail = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Drives one capture/recovery episode from IDLE and checks every observable cycle.
    task automatic run_scenario(input logic [ErrW-1:0] ev);
        int order[$];
        int intr0, rise0, exp_rises;
        bit failed;
        for (int i = 0; i < int'(ErrW); i++) if (ev[i]) order.push_back(i);
        intr0 = intr_cnt;
        rise0 = rise_cnt;
        exp_rises = 0;

        error = ev;
        tick();
        error = '0;
        chk("capture_interrupt", 32'(interrupt), 1);
        chk("capture_busy", 32'(busy), 1);
        tick();
        chk("select_interrupt", 32'(interrupt), 0);
        chk("select_req", 32'(recover_req), 0);

        foreach (order[k]) begin
            int m;
            m = order[k];
            for (int attempt = 0; ; attempt++) begin
                tick();
                recover_ack = 1'b0;
                recover_fail = 1'b0;
                chk("req_start", 32'(recover_req), 1);
                chk("req_idx", 32'(recover_idx), 32'(m));
                exp_rises++;
                if (delay_plan[m] < 0) begin
                    for (int c = 1; c < int'(AckTimeout); c++) begin
                        tick();
                        chk("timeout_wait_req", 32'(recover_req), 1);
                    end
                    tick();
                    chk("timeout_fatal", 32'(fatal), 1);
                    chk("timeout_req", 32'(recover_req), 0);
                    chk("timeout_busy", 32'(busy), 0);
                    return;
                end
                for (int d = 0; d < delay_plan[m]; d++) begin
                    tick();
                    error = 24'($urandom);
                    recover_fail = 1'($urandom);
                    chk("req_hold", 32'(recover_req), 1);
                    chk("idx_hold", 32'(recover_idx), 32'(m));
                end
                failed = (attempt < fails_plan[m]);
                recover_ack = 1'b1;
                recover_fail = failed;
                tick();
                recover_ack = 1'b0;
                recover_fail = 1'b0;
                error = '0;
                if (failed && attempt == int'(MaxRetries)) begin
                    chk("fail_fatal", 32'(fatal), 1);
                    chk("fail_req", 32'(recover_req), 0);
                    chk("fail_busy", 32'(busy), 0);
                    chk("fail_count", 32'(err_count), 32'(exp_cnt));
                    chk("fail_rises", 32'(rise_cnt - rise0), 32'(exp_rises));
                    return;
                end
                chk("post_ack_req", 32'(recover_req), 0);
                chk("post_ack_busy", 32'(busy), 1);
                // An ack outside REQUEST must be ignored.
                recover_ack = 1'($urandom);
                recover_fail = 1'($urandom);
                if (!failed) begin
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                    break;
                end
            end
        end

        tick();
        recover_ack = 1'b0;
        recover_fail = 1'b0;
        chk("done_busy", 32'(busy), 1);
        chk("done_req", 32'(recover_req), 0);
        tick();
        chk("idle_busy", 32'(busy), 0);
        chk("idle_count", 32'(err_count), 32'(exp_cnt));
        chk("idle_fatal", 32'(fatal), 0);
        chk("interrupt_once", 32'(intr_cnt - intr0), 1);
        chk("req_rises", 32'(rise_cnt - rise0), 32'(exp_rises));
    endtask

    initial begin
        logic [ErrW-1:0] ev;
        rst = 1'b0;
        error = '0;
        recover_ack = 1'b0;
        recover_fail = 1'b0;
        exp_cnt = '0;
        #2;
        apply_reset();

        // Single memory, ack after two cycles.
        clear_plan();
        delay_plan[0] = 2;
        run_scenario(24'h000001);

        // Three memories, immediate success acks.
        clear_plan();
        run_scenario(24'h800011);

        // Two failures then success on memory 5.
        clear_plan();
        fails_plan[5] = 2;
        delay_plan[5] = 1;
        run_scenario(24'h000020);

        // Randomized vectors and response plans, all eventually succeeding.
        for (int r = 0; r < 6; r++) begin
            ev = 24'($urandom & $urandom & $urandom);
            if (ev == '0) ev = 24'(1) << $urandom_range(0, 23);
            for (int i = 0; i < int'(ErrW); i++) begin
                fails_plan[i] = $urandom_range(0, MaxRetries);
                delay_plan[i] = $urandom_range(0, 4);
            end
            run_scenario(ev);
        end

        // Four failures on memory 7 escalate to fatal, which then ignores all inputs.
        clear_plan();
        fails_plan[7] = 4;
        run_scenario(24'h000080);
        error = 24'h000001;
        recover_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("fatal_sticky", 32'(fatal), 1);
            chk("fatal_no_req", 32'(recover_req), 0);
            chk("fatal_no_intr", 32'(interrupt), 0);
            chk("fatal_no_busy", 32'(busy), 0);
        end
        chk("fatal_count", 32'(err_count), 32'(exp_cnt));
        apply_reset();

        // No ack on memory 2: timeout escalates to fatal.
        clear_plan();
        delay_plan[2] = -1;
        run_scenario(24'h000004);
        apply_reset();

        // Reset asserted mid-request aborts immediately and leaves the block quiet.
        error = 24'h000008;
        tick();
        error = '0;
        tick();
        tick();
        chk("abort_req_before", 32'(recover_req), 1);
        chk("abort_idx_before", 32'(recover_idx), 3);
        #2;
        apply_reset();
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("quiet_after_reset", 32'({interrupt, recover_req, busy, fatal}), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_error_recovery_ctrl.md
Name: mem_error_recovery_ctrl

Overview:
- Sequences recovery after the memory error detector flags faults in the LABFT array memories.
- Latches the 6*arraySize error vector and pulses `interrupt` to re-arm the detector.
- Walks the flagged memories lowest index first, issuing one recompute/reload request per memory over a req/ack handshake.
- Handles bounded retries and an ack timeout; escalates to a sticky `fatal` flag when recovery cannot complete.

Parameters:
- arraySize, 4, systolic array dimension; error vector width is 6*arraySize.
- maxRetries, 3, extra attempts allowed per memory after a failed recovery.
- ackTimeout, 255, maximum cycles to wait for `recover_ack` before declaring fatal.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- error  in  6*arraySize  registered error flags from the detector; bit i = memory i faulty.
- interrupt  out  1  one-cycle pulse that returns the detector to idle.
- recover_req  out  1  recovery request for memory `recover_idx`.
- recover_idx  out  $clog2(6*arraySize)  index of the memory being recovered; stable while `recover_req`=1.
- recover_ack  in  1  one-cycle completion strobe from the recovery datapath.
- recover_fail  in  1  qualified by `recover_ack`; 1 = fault persists after recovery.
- busy  out  1  high in every state except IDLE and FATAL.
- fatal  out  1  sticky unrecoverable-error flag.
- err_count  out  16  saturating count of successfully recovered memories.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; pending=0; retry=0; timer=0; err_count=0; all outputs 0.
- All outputs are registered or decoded from registered state (Moore). No combinational path from inputs to outputs.
- States: IDLE, CAPTURE, SELECT, REQUEST, RETRY, DONE, FATAL.
- IDLE:
  - error==0: remain in IDLE.
  - error!=0: pending<=error, go to CAPTURE.
- CAPTURE: `interrupt`=1 for exactly this cycle; go to SELECT.
- SELECT:
  - pending==0: go to DONE.
  - Otherwise: idx<=lowest set bit of pending; retry<=0; timer<=0; go to REQUEST.
- REQUEST:
  - `recover_req`=1 and `recover_idx`=idx; timer increments each cycle.
  - ack with fail=0: clear pending[idx]; err_count+1 (saturates at 16'hFFFF); go to SELECT.
  - ack with fail=1 and retry<maxRetries: retry+1; timer<=0; go to RETRY.
  - ack with fail=1 and retry==maxRetries: go to FATAL.
  - No ack and timer==ackTimeout-1: go to FATAL.
- RETRY: `recover_req`=0 for one cycle; go to REQUEST. Every retry therefore produces a new rising edge on `recover_req`.
- DONE: one cycle; go to IDLE. `error` is sampled again only in IDLE.
- FATAL: `fatal`=1, `recover_req`=0, `busy`=0; state is held until rst.
- `error` is ignored in every state except IDLE. New flags raised during recovery are lost by design, because `interrupt` has already idled the detector.
- `recover_ack` is ignored outside REQUEST. `recover_fail` is ignored when `recover_ack`=0.
- Latency:
  - error!=0 at edge N → `interrupt` high in cycle N+1 → `recover_req` high in cycle N+3.
  - An ack at edge M → next request (different idx) high in cycle M+2.
- Total attempts per memory = maxRetries+1.
- Reset asserted mid-operation aborts immediately. No `interrupt` or `recover_req` appears after rst is released until a fresh non-zero `error` is seen in IDLE.

Test Plan:
- arraySize=4, error=24'h000001, ack with fail=0 after 2 cycles → single request, idx=0; err_count=1; `busy` falls 2 cycles after ack; `interrupt` pulsed exactly once.
- error=24'h800011, each request acked with fail=0 → idx sequence 0, 4, 23; err_count=3; each request starts 2 cycles after the previous ack.
- error bit 5, responses fail, fail, success (maxRetries=3) → three req pulses on idx=5, each separated by one low cycle; err_count=1; `fatal`=0.
- error bit 7, four consecutive fail acks → `fatal`=1 in the cycle after the 4th ack; `recover_req`=0; `busy`=0; a later error=1 and ack have no effect.
- error bit 2, `recover_ack` never asserted → `fatal`=1 exactly 255 cycles after `recover_req` rose.
- rst driven low while in REQUEST with idx=3 → all outputs 0 without waiting for a clock edge; after release with error=0 there is no activity for 20 cycles.
